ex_ctrl_sequencer: RTL and testbench
====================================

Name: ex_ctrl_sequencer

Overview:
- Execute-stage control sequencer between decode (ID) and execute (EX).
- Registers ID control fields (ALU op, operand selects, writeback select, branch op) into EX with a valid/ready handshake.
- Inserts load-use bubbles and discards wrong-path decode slots after a taken branch or jump.
- Drives the ALU, operand muxes and branch compare unit through control_pkg enum types.

Parameters:
- FLUSH_CYCLES, 1, decode slots discarded after a redirect (legal 0..7).
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_valid_i  in  1  decode slot holds an instruction
- id_ready_o  out  1  sequencer consumes the decode slot this cycle
- id_alu_op_i  in  4  e_alu_operation_sel
- id_op_a_sel_i  in  2  e_alu_operand_a_sel
- id_op_b_sel_i  in  1  e_alu_operand_b_sel
- id_wb_sel_i  in  2  e_regfile_wb_sel
- id_branch_i  in  1  conditional branch
- id_jump_i  in  1  JAL/JALR
- id_branch_op_i  in  3  e_branch_operation_sel
- id_mem_read_i  in  1  load
- id_rd_we_i  in  1  writes rd
- id_rd_i, id_rs1_i, id_rs2_i  in  REG_ADDR_W  register indices
- ex_ready_i  in  1  downstream (MEM) accepts the EX instruction
- branch_result_i  in  1  e_branch_result for the current EX instruction (combinational from compare unit)
- ex_valid_o  out  1  EX holds a live instruction
- ex_alu_op_o, ex_op_a_sel_o, ex_op_b_sel_o, ex_wb_sel_o, ex_branch_op_o  out  4/2/1/2/3  registered controls
- ex_mem_read_o, ex_rd_we_o  out  1  registered
- ex_rd_o  out  REG_ADDR_W  registered
- flush_o  out  1  redirect pulse to fetch/decode

Behaviour:
- Reset (sync, rst=1 at posedge):
  - ex_valid_o=0, ex_alu_op_o=ALU_ADD, ex_op_a_sel_o=ALU_RS1, ex_op_b_sel_o=ALU_RS2, ex_wb_sel_o=WB_ALU_OUT, ex_branch_op_o=CMP_BEQ.
  - ex_mem_read_o=0, ex_rd_we_o=0, ex_rd_o=0.
  - State=RUN, redirect counter=0.
  - id_ready_o and flush_o evaluate to 0 while rst=1.
  - Reset mid-REDIRECT aborts to RUN.
- slot_free = !ex_valid_o | ex_ready_i.
- redirect = ex_valid_o & ex_ready_i & (ex_jump | (ex_branch & branch_result_i==BRANCH_TAKEN)). ex_jump/ex_branch are internal registered copies.
- hazard = ex_valid_o & ex_mem_read_o & ex_rd_o!=0 & (id_rs1_i==ex_rd_o | id_rs2_i==ex_rd_o). The compare is conservative: it applies regardless of operand use.
- Priority: rst > redirect > state REDIRECT > hazard > normal advance.
- State RUN:
  - redirect: flush_o=1 (combinational, same cycle); id_ready_o=1 (the wrong-path ID slot is dropped). Next cycle ex_valid_o=0. Counter loads FLUSH_CYCLES; go to REDIRECT if FLUSH_CYCLES>0, else stay in RUN.
  - hazard & slot_free: id_ready_o=0, ex_valid_o<=0 (one bubble). The hazard clears automatically next cycle.
  - slot_free otherwise: id_ready_o=1; EX registers load ID fields; ex_valid_o<=id_valid_i.
  - !slot_free: id_ready_o=0; all EX registers hold.
- State REDIRECT:
  - id_ready_o=1, ex_valid_o<=0, flush_o=0.
  - Counter decrements only on cycles with id_valid_i=1 (a consumed slot).
  - Go to RUN when a consumed slot brings the counter from 1 to 0.
- EX control registers load only when ex_valid_o is set from a valid ID slot. On bubbles they keep their last value; downstream qualifies them with ex_valid_o.
- Latency: an ID instruction accepted at cycle N appears on ex_* at N+1.
- Back-to-back accepts sustain 1 instruction/cycle with no hazard.

Optional Feature:
- Macro: EX_CTRL_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cnt_o[31:0] and perf_flush_cnt_o[31:0]. Both reset to 0 and wrap modulo 2^32.
  - Stall count increments on each hazard-bubble cycle.
  - Flush count increments on each flush_o pulse.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset → all ex_* outputs equal their reset values above; flush_o=0, id_ready_o=0 while rst=1. Assert rst while in REDIRECT → state returns to RUN, counter=0.
- Stream ADDI x1 (op=ALU_ADD, b=ALU_IMM), SUB x2 (op=ALU_SUB), ex_ready_i=1 → ex_alu_op_o shows 4'b0000 then 4'b1000 on consecutive cycles, ex_valid_o=1 throughout.
- LW x5 in EX, then ADD x6,x5,x7 in ID → id_ready_o=0 for one cycle, ex_valid_o=0 for exactly one cycle, then ADD enters EX.
- BEQ in EX with branch_result_i=1, FLUSH_CYCLES=1, id_valid_i=1 → flush_o=1 for one cycle; the next two ID slots are consumed and dropped; the third reaches EX.
- ex_ready_i=0 for 3 cycles with EX valid (op=ALU_SRA) → ex_* held at 4'b1101, id_ready_o=0; resumes on release.
- Redirect and hazard in the same cycle → flush wins, no extra bubble; with EX_CTRL_PERF_CNT_EN, perf_flush_cnt_o=1 and perf_stall_cnt_o=0.

Source files
------------

// File: rtl/ex_ctrl_sequencer_if.sv
// Control encodings shared by decode, the EX sequencer and the execute units,
// plus the ID->EX handshake/bus interface of ex_ctrl_sequencer.
// slave modport: the sequencer. master modport: decode/MEM/compare side.

package control_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } e_alu_operation_sel;

   typedef enum logic [1:0] {
      ALU_RS1  = 2'd0,
      ALU_PC   = 2'd1,
      ALU_ZERO = 2'd2
   } e_alu_operand_a_sel;

   typedef enum logic {
      ALU_RS2 = 1'b0,
      ALU_IMM = 1'b1
   } e_alu_operand_b_sel;

   typedef enum logic [1:0] {
      WB_ALU_OUT  = 2'd0,
      WB_MEM_OUT  = 2'd1,
      WB_PC_PLUS4 = 2'd2,
      WB_CSR      = 2'd3
   } e_regfile_wb_sel;

   typedef enum logic [2:0] {
      CMP_BEQ  = 3'd0,
      CMP_BNE  = 3'd1,
      CMP_BLT  = 3'd4,
      CMP_BGE  = 3'd5,
      CMP_BLTU = 3'd6,
      CMP_BGEU = 3'd7
   } e_branch_operation_sel;

   typedef enum logic {
      BRANCH_NOT_TAKEN = 1'b0,
      BRANCH_TAKEN     = 1'b1
   } e_branch_result;

endpackage

interface ex_ctrl_sequencer_if #(
   parameter int unsigned REG_ADDR_W = 5
);
   // decode slot
   logic                               id_valid_i;
   logic                               id_ready_o;
   control_pkg::e_alu_operation_sel    id_alu_op_i;
   control_pkg::e_alu_operand_a_sel    id_op_a_sel_i;
   control_pkg::e_alu_operand_b_sel    id_op_b_sel_i;
   control_pkg::e_regfile_wb_sel       id_wb_sel_i;
   logic                               id_branch_i;
   logic                               id_jump_i;
   control_pkg::e_branch_operation_sel id_branch_op_i;
   logic                               id_mem_read_i;
   logic                               id_rd_we_i;
   logic [REG_ADDR_W-1:0]              id_rd_i;
   logic [REG_ADDR_W-1:0]              id_rs1_i;
   logic [REG_ADDR_W-1:0]              id_rs2_i;
   // execute stage
   logic                               ex_ready_i;
   control_pkg::e_branch_result        branch_result_i;
   logic                               ex_valid_o;
   control_pkg::e_alu_operation_sel    ex_alu_op_o;
   control_pkg::e_alu_operand_a_sel    ex_op_a_sel_o;
   control_pkg::e_alu_operand_b_sel    ex_op_b_sel_o;
   control_pkg::e_regfile_wb_sel       ex_wb_sel_o;
   control_pkg::e_branch_operation_sel ex_branch_op_o;
   logic                               ex_mem_read_o;
   logic                               ex_rd_we_o;
   logic [REG_ADDR_W-1:0]              ex_rd_o;
   logic                               flush_o;

   modport slave (
      input  id_valid_i, id_alu_op_i, id_op_a_sel_i, id_op_b_sel_i, id_wb_sel_i,
             id_branch_i, id_jump_i, id_branch_op_i, id_mem_read_i, id_rd_we_i,
             id_rd_i, id_rs1_i, id_rs2_i, ex_ready_i, branch_result_i,
      output id_ready_o, ex_valid_o, ex_alu_op_o, ex_op_a_sel_o, ex_op_b_sel_o,
             ex_wb_sel_o, ex_branch_op_o, ex_mem_read_o, ex_rd_we_o, ex_rd_o, flush_o
   );

   modport master (
      output id_valid_i, id_alu_op_i, id_op_a_sel_i, id_op_b_sel_i, id_wb_sel_i,
             id_branch_i, id_jump_i, id_branch_op_i, id_mem_read_i, id_rd_we_i,
             id_rd_i, id_rs1_i, id_rs2_i, ex_ready_i, branch_result_i,
      input  id_ready_o, ex_valid_o, ex_alu_op_o, ex_op_a_sel_o, ex_op_b_sel_o,
             ex_wb_sel_o, ex_branch_op_o, ex_mem_read_o, ex_rd_we_o, ex_rd_o, flush_o
   );

endinterface

// File: rtl/ex_ctrl_sequencer.sv
// Execute-stage control sequencer: registers ID control fields into EX with a
// valid/ready handshake, inserts load-use bubbles and drops wrong-path decode
// slots after a taken branch or jump.
// Optional: define EX_CTRL_PERF_CNT_EN to add stall/flush event counters.

module ex_ctrl_sequencer #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned REG_ADDR_W   = 5
) (
   input  logic                clk,
   input  logic                rst,
   ex_ctrl_sequencer_if.slave  bus
`ifdef EX_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]         perf_stall_cnt_o,
   output logic [31:0]         perf_flush_cnt_o
`endif
);

   import control_pkg::*;

   typedef enum logic {
      ST_RUN,
      ST_REDIRECT
   } state_t;

   localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_CYCLES);

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  ex_valid_q, ex_valid_d;
   logic                  load_ex;
   logic                  id_ready;
   logic                  flush;
   logic                  slot_free;
   logic                  redirect;
   logic                  hazard;

   e_alu_operation_sel    ex_alu_op_q;
   e_alu_operand_a_sel    ex_op_a_sel_q;
   e_alu_operand_b_sel    ex_op_b_sel_q;
   e_regfile_wb_sel       ex_wb_sel_q;
   e_branch_operation_sel ex_branch_op_q;
   logic                  ex_mem_read_q;
   logic                  ex_rd_we_q;
   logic [REG_ADDR_W-1:0] ex_rd_q;
   logic                  ex_jump_q;
   logic                  ex_branch_q;

   assign slot_free = !ex_valid_q || bus.ex_ready_i;
   assign redirect  = ex_valid_q && bus.ex_ready_i &&
                      (ex_jump_q || (ex_branch_q && bus.branch_result_i == BRANCH_TAKEN));
   // Conservative: compares both source fields whether or not they are used.
   assign hazard    = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
                      ((bus.id_rs1_i == ex_rd_q) || (bus.id_rs2_i == ex_rd_q));

   // Next-state and handshake decode; priority rst > redirect > REDIRECT > hazard > advance.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ex_valid_d = ex_valid_q;
      load_ex    = 1'b0;
      id_ready   = 1'b0;
      flush      = 1'b0;
      if (!rst) begin
         if (redirect) begin
            flush      = 1'b1;
            id_ready   = 1'b1;
            ex_valid_d = 1'b0;
            cnt_d      = FLUSH_CNT;
            state_d    = (FLUSH_CYCLES > 0) ? ST_REDIRECT : ST_RUN;
         end else if (state_q == ST_REDIRECT) begin
            id_ready   = 1'b1;
            ex_valid_d = 1'b0;
            if (bus.id_valid_i) begin
               if (cnt_q <= 3'd1) begin
                  cnt_d   = '0;
                  state_d = ST_RUN;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
         end else if (hazard && slot_free) begin
            ex_valid_d = 1'b0;
         end else if (slot_free) begin
            id_ready   = 1'b1;
            ex_valid_d = bus.id_valid_i;
            load_ex    = bus.id_valid_i;
         end
      end
   end

   // Sequencer state, redirect counter and EX valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         ex_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ex_valid_q <= ex_valid_d;
      end
   end

   // EX control registers; they only change when a valid ID slot is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_alu_op_q    <= ALU_ADD;
         ex_op_a_sel_q  <= ALU_RS1;
         ex_op_b_sel_q  <= ALU_RS2;
         ex_wb_sel_q    <= WB_ALU_OUT;
         ex_branch_op_q <= CMP_BEQ;
         ex_mem_read_q  <= 1'b0;
         ex_rd_we_q     <= 1'b0;
         ex_rd_q        <= '0;
         ex_jump_q      <= 1'b0;
         ex_branch_q    <= 1'b0;
      end else if (load_ex) begin
         ex_alu_op_q    <= bus.id_alu_op_i;
         ex_op_a_sel_q  <= bus.id_op_a_sel_i;
         ex_op_b_sel_q  <= bus.id_op_b_sel_i;
         ex_wb_sel_q    <= bus.id_wb_sel_i;
         ex_branch_op_q <= bus.id_branch_op_i;
         ex_mem_read_q  <= bus.id_mem_read_i;
         ex_rd_we_q     <= bus.id_rd_we_i;
         ex_rd_q        <= bus.id_rd_i;
         ex_jump_q      <= bus.id_jump_i;
         ex_branch_q    <= bus.id_branch_i;
      end
   end

   assign bus.id_ready_o     = id_ready;
   assign bus.flush_o        = flush;
   assign bus.ex_valid_o     = ex_valid_q;
   assign bus.ex_alu_op_o    = ex_alu_op_q;
   assign bus.ex_op_a_sel_o  = ex_op_a_sel_q;
   assign bus.ex_op_b_sel_o  = ex_op_b_sel_q;
   assign bus.ex_wb_sel_o    = ex_wb_sel_q;
   assign bus.ex_branch_op_o = ex_branch_op_q;
   assign bus.ex_mem_read_o  = ex_mem_read_q;
   assign bus.ex_rd_we_o     = ex_rd_we_q;
   assign bus.ex_rd_o        = ex_rd_q;

`ifdef EX_CTRL_PERF_CNT_EN
   logic stall_evt;

   // A hazard bubble is only issued in RUN when no redirect pre-empts it.
   assign stall_evt = !rst && !redirect && (state_q == ST_RUN) && hazard && slot_free;

   // Free-running event counters, wrapping modulo 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt_o <= '0;
         perf_flush_cnt_o <= '0;
      end else begin
         if (stall_evt) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
         if (flush)     perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ex_ctrl_sequencer.sv
// Directed bench for ex_ctrl_sequencer: accepted ID slots are pushed to a
// scoreboard and popped when EX is expected to show a live instruction.

module tb_ex_ctrl_sequencer;

   import control_pkg::*;

   localparam int unsigned RW = 5;

   typedef struct {
      e_alu_operation_sel    alu;
      e_alu_operand_a_sel    a;
      e_alu_operand_b_sel    b;
      e_regfile_wb_sel       wb;
      e_branch_operation_sel bop;
      logic                  mr;
      logic                  we;
      logic [RW-1:0]         rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_ctrl_sequencer_if #(.REG_ADDR_W(RW)) bus ();

`ifdef EX_CTRL_PERF_CNT_EN
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;
`endif

   ex_ctrl_sequencer #(
      .FLUSH_CYCLES(1),
      .REG_ADDR_W  (RW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef EX_CTRL_PERF_CNT_EN
      ,
      .perf_stall_cnt_o (perf_stall),
      .perf_flush_cnt_o (perf_flush)
`endif
   );

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t last;
   exp_t rst_e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input e_alu_operation_sel op,
                         input e_alu_operand_a_sel a, input e_alu_operand_b_sel b,
                         input e_regfile_wb_sel wb, input logic br, input logic jmp,
                         input e_branch_operation_sel bop, input logic mr, input logic we,
                         input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                         input logic [RW-1:0] rs2);
      bus.id_valid_i     = v;
      bus.id_alu_op_i    = op;
      bus.id_op_a_sel_i  = a;
      bus.id_op_b_sel_i  = b;
      bus.id_wb_sel_i    = wb;
      bus.id_branch_i    = br;
      bus.id_jump_i      = jmp;
      bus.id_branch_op_i = bop;
      bus.id_mem_read_i  = mr;
      bus.id_rd_we_i     = we;
      bus.id_rd_i        = rd;
      bus.id_rs1_i       = rs1;
      bus.id_rs2_i       = rs2;
   endtask

   // Checks handshake outputs mid-cycle, records the slot if it should be
   // accepted, then advances one clock and settles.
   task automatic cyc(input logic exp_rdy, input logic exp_flush, input logic push,
                      input string tag);
      exp_t e;
      #2;
      check({tag, ".id_ready"}, 32'(bus.id_ready_o), 32'(exp_rdy));
      check({tag, ".flush"}, 32'(bus.flush_o), 32'(exp_flush));
      if (push) begin
         e.alu = bus.id_alu_op_i;
         e.a   = bus.id_op_a_sel_i;
         e.b   = bus.id_op_b_sel_i;
         e.wb  = bus.id_wb_sel_i;
         e.bop = bus.id_branch_op_i;
         e.mr  = bus.id_mem_read_i;
         e.we  = bus.id_rd_we_i;
         e.rd  = bus.id_rd_i;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_fields(input string tag, input exp_t e);
      check({tag, ".alu_op"}, 32'(bus.ex_alu_op_o), 32'(e.alu));
      check({tag, ".op_a"}, 32'(bus.ex_op_a_sel_o), 32'(e.a));
      check({tag, ".op_b"}, 32'(bus.ex_op_b_sel_o), 32'(e.b));
      check({tag, ".wb_sel"}, 32'(bus.ex_wb_sel_o), 32'(e.wb));
      check({tag, ".br_op"}, 32'(bus.ex_branch_op_o), 32'(e.bop));
      check({tag, ".mem_rd"}, 32'(bus.ex_mem_read_o), 32'(e.mr));
      check({tag, ".rd_we"}, 32'(bus.ex_rd_we_o), 32'(e.we));
      check({tag, ".rd"}, 32'(bus.ex_rd_o), 32'(e.rd));
   endtask

   task automatic chk_ex(input logic exp_valid, input string tag);
      check({tag, ".ex_valid"}, 32'(bus.ex_valid_o), 32'(exp_valid));
      if (exp_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s.scoreboard: observed empty expected entry", tag);
         end else begin
            last = sb.pop_front();
            cmp_fields(tag, last);
         end
      end
   endtask

   initial begin
      rst_e = '{ALU_ADD, ALU_RS1, ALU_RS2, WB_ALU_OUT, CMP_BEQ, 1'b0, 1'b0, '0};

      // reset with junk on every input
      rst = 1'b1;
      bus.ex_ready_i      = 1'b1;
      bus.branch_result_i = BRANCH_TAKEN;
      set_id(1, ALU_SUB, ALU_PC, ALU_IMM, WB_MEM_OUT, 1, 1, CMP_BGE, 1, 1, 5'd3, 5'd3, 5'd3);
      cyc(0, 0, 0, "rst");
      check("rst.ex_valid", 32'(bus.ex_valid_o), 32'd0);
      cmp_fields("rst", rst_e);
      rst = 1'b0;
      bus.branch_result_i = BRANCH_NOT_TAKEN;

      // ADDI x1 then SUB x2 back to back
      set_id(1, ALU_ADD, ALU_RS1, ALU_IMM, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd1, 5'd0, 5'd0);
      cyc(1, 0, 1, "addi");
      chk_ex(1, "addi");
      check("addi.code", 32'(bus.ex_alu_op_o), 32'b0000);
      set_id(1, ALU_SUB, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd2, 5'd3, 5'd4);
      cyc(1, 0, 1, "sub");
      chk_ex(1, "sub");
      check("sub.code", 32'(bus.ex_alu_op_o), 32'b1000);

      // LW x5 then ADD x6,x5,x7: one bubble on rs1
      set_id(1, ALU_ADD, ALU_RS1, ALU_IMM, WB_MEM_OUT, 0, 0, CMP_BEQ, 1, 1, 5'd5, 5'd2, 5'd0);
      cyc(1, 0, 1, "lw5");
      chk_ex(1, "lw5");
      set_id(1, ALU_ADD, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd6, 5'd5, 5'd7);
      cyc(0, 0, 0, "luse1");
      chk_ex(0, "luse1.bubble");
      cyc(1, 0, 1, "luse1.retry");
      chk_ex(1, "add6");

      // load into x0 never stalls a consumer of x0
      set_id(1, ALU_ADD, ALU_RS1, ALU_IMM, WB_MEM_OUT, 0, 0, CMP_BEQ, 1, 1, 5'd0, 5'd1, 5'd0);
      cyc(1, 0, 1, "lw0");
      chk_ex(1, "lw0");
      set_id(1, ALU_ADD, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd8, 5'd0, 5'd0);
      cyc(1, 0, 1, "x0dep");
      chk_ex(1, "x0dep");

      // LW x9 then ADD x10,x1,x9: one bubble on rs2
      set_id(1, ALU_ADD, ALU_RS1, ALU_IMM, WB_MEM_OUT, 0, 0, CMP_BEQ, 1, 1, 5'd9, 5'd1, 5'd0);
      cyc(1, 0, 1, "lw9");
      chk_ex(1, "lw9");
      set_id(1, ALU_ADD, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd10, 5'd1, 5'd9);
      cyc(0, 0, 0, "luse2");
      chk_ex(0, "luse2.bubble");
      cyc(1, 0, 1, "luse2.retry");
      chk_ex(1, "add10");

      // BNE not taken: no redirect
      set_id(1, ALU_SUB, ALU_RS1, ALU_RS2, WB_ALU_OUT, 1, 0, CMP_BNE, 0, 0, 5'd0, 5'd1, 5'd2);
      cyc(1, 0, 1, "bne");
      chk_ex(1, "bne");
      set_id(1, ALU_ADD, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd11, 5'd1, 5'd2);
      cyc(1, 0, 1, "bne.fall");
      chk_ex(1, "bne.fall");

      // BEQ taken: two consumed slots dropped (idle cycle in between does not count)
      set_id(1, ALU_SUB, ALU_RS1, ALU_RS2, WB_ALU_OUT, 1, 0, CMP_BEQ, 0, 0, 5'd0, 5'd1, 5'd1);
      cyc(1, 0, 1, "beq");
      chk_ex(1, "beq");
      bus.branch_result_i = BRANCH_TAKEN;
      set_id(1, ALU_ADD, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd20, 5'd1, 5'd2);
      cyc(1, 1, 0, "beq.redir");
      chk_ex(0, "beq.redir");
      bus.branch_result_i = BRANCH_NOT_TAKEN;
      set_id(0, ALU_OR, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd22, 5'd1, 5'd2);
      cyc(1, 0, 0, "redir.idle");
      chk_ex(0, "redir.idle");
      set_id(1, ALU_ADD, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd21, 5'd1, 5'd2);
      cyc(1, 0, 0, "redir.drop");
      chk_ex(0, "redir.drop");
      set_id(1, ALU_XOR, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd12, 5'd1, 5'd2);
      cyc(1, 0, 1, "target");
      chk_ex(1, "target");

      // SRA held for three cycles of back-pressure
      set_id(1, ALU_SRA, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd13, 5'd12, 5'd1);
      cyc(1, 0, 1, "sra");
      chk_ex(1, "sra");
      bus.ex_ready_i = 1'b0;
      set_id(1, ALU_ADD, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd14, 5'd1, 5'd2);
      for (int unsigned i = 0; i < 3; i++) begin
         cyc(0, 0, 0, "hold");
         check("hold.ex_valid", 32'(bus.ex_valid_o), 32'd1);
         check("hold.code", 32'(bus.ex_alu_op_o), 32'b1101);
         cmp_fields("hold", last);
      end
      bus.ex_ready_i = 1'b1;
      cyc(1, 0, 1, "release");
      chk_ex(1, "release");

      // idle slot: bubble, controls keep last value
      set_id(0, ALU_OR, ALU_PC, ALU_IMM, WB_CSR, 0, 0, CMP_BGEU, 1, 0, 5'd30, 5'd1, 5'd2);
      cyc(1, 0, 0, "idle");
      chk_ex(0, "idle");
      cmp_fields("idle.keep", last);

`ifdef EX_CTRL_PERF_CNT_EN
      check("perf.stall", perf_stall, 32'd2);
      check("perf.flush", perf_flush, 32'd1);
`endif

      // second reset clears everything
      rst = 1'b1;
      cyc(0, 0, 0, "rst2");
      check("rst2.ex_valid", 32'(bus.ex_valid_o), 32'd0);
      cmp_fields("rst2", rst_e);
`ifdef EX_CTRL_PERF_CNT_EN
      check("rst2.perf_stall", perf_stall, 32'd0);
      check("rst2.perf_flush", perf_flush, 32'd0);
`endif
      rst = 1'b0;

      // jump that is also a load to x1, ID reads x1: redirect wins, no bubble
      set_id(1, ALU_ADD, ALU_PC, ALU_IMM, WB_PC_PLUS4, 0, 1, CMP_BEQ, 1, 1, 5'd1, 5'd0, 5'd0);
      cyc(1, 0, 1, "jal");
      chk_ex(1, "jal");
      set_id(1, ALU_ADD, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd15, 5'd1, 5'd2);
      cyc(1, 1, 0, "jal.redir");
      chk_ex(0, "jal.redir");
`ifdef EX_CTRL_PERF_CNT_EN
      check("jal.perf_flush", perf_flush, 32'd1);
      check("jal.perf_stall", perf_stall, 32'd0);
`endif

      // reset while in REDIRECT: the next slot must be accepted
      rst = 1'b1;
      set_id(1, ALU_ADD, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd16, 5'd1, 5'd2);
      cyc(0, 0, 0, "rst3");
      chk_ex(0, "rst3");
      rst = 1'b0;
      set_id(1, ALU_AND, ALU_RS1, ALU_RS2, WB_ALU_OUT, 0, 0, CMP_BEQ, 0, 1, 5'd17, 5'd1, 5'd2);
      cyc(1, 0, 1, "post_rst");
      chk_ex(1, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
